datapath: RTL and testbench

- Phase-1 CPU datapath: 16 general registers (R0–R15), HI, LO, PC, MAR, MDR, Y, 64-bit Z, InPort and C registers, all joined by one shared 32-bit bus, plus a combinational ALU.
- An external sequencer or testbench drives every control strobe directly; there is no internal control unit.
- Memory is modelled by the Mdatain input.

---
 rtl/datapath_pkg.sv | 26 ++
 rtl/datapath_alu.sv | 70 +++++++
 rtl/datapath.sv | 127 ++++++++++++
 tb/tb_datapath.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/datapath_pkg.sv
// Shared constants for the phase-1 datapath: bus width and ALU opcodes.
package datapath_pkg;

    localparam int unsigned WIDTH = 32;

    localparam logic [4:0] OP_ADD_ALT0 = 5'b00000;
    localparam logic [4:0] OP_ADD_ALT1 = 5'b00001;
    localparam logic [4:0] OP_ADD_ALT2 = 5'b00010;
    localparam logic [4:0] OP_ADD      = 5'b00011;
    localparam logic [4:0] OP_SUB      = 5'b00100;
    localparam logic [4:0] OP_AND      = 5'b00101;
    localparam logic [4:0] OP_OR       = 5'b00110;
    localparam logic [4:0] OP_SHR      = 5'b00111;
    localparam logic [4:0] OP_SHRA     = 5'b01000;
    localparam logic [4:0] OP_SHL      = 5'b01001;
    localparam logic [4:0] OP_ROR      = 5'b01010;
    localparam logic [4:0] OP_ROL      = 5'b01011;
    localparam logic [4:0] OP_ADD_ALT3 = 5'b01100;
    localparam logic [4:0] OP_AND_ALT  = 5'b01101;
    localparam logic [4:0] OP_OR_ALT   = 5'b01110;
    localparam logic [4:0] OP_MUL      = 5'b01111;
    localparam logic [4:0] OP_DIV      = 5'b10000;
    localparam logic [4:0] OP_NEG      = 5'b10001;
    localparam logic [4:0] OP_NOT      = 5'b10010;

endpackage

// File: rtl/datapath_alu.sv
// Combinational ALU: A operand is Y, B operand is the bus; 64-bit result feeds Z.
module datapath_alu
    import datapath_pkg::*;
#(
    parameter int unsigned WIDTH = datapath_pkg::WIDTH
) (
    input  logic [WIDTH-1:0]   y_i,
    input  logic [WIDTH-1:0]   bus_i,
    input  logic [4:0]         opcode_i,
    output logic [2*WIDTH-1:0] result_o
);

    localparam int unsigned ShW = $clog2(WIDTH);

    logic [ShW-1:0]           sh;
    logic [ShW-1:0]           sh_inv;
    logic signed [2*WIDTH-1:0] prod;
    logic signed [WIDTH-1:0]  quot;
    logic signed [WIDTH-1:0]  rem;
    logic [WIDTH-1:0]         lo;
    logic [WIDTH-1:0]         hi;

    assign sh     = bus_i[ShW-1:0];
    // Complementary rotate amount; sh == 0 gives 0, so both halves equal y and OR cleanly.
    assign sh_inv = -sh;

    assign prod = $signed({{WIDTH{y_i[WIDTH-1]}}, y_i}) *
                  $signed({{WIDTH{bus_i[WIDTH-1]}}, bus_i});

    // Signed divide truncating toward zero; divide by zero yields all-ones and remainder = A.
    always_comb begin
        quot = '1;
        rem  = $signed(y_i);
        if (bus_i != '0) begin
            quot = $signed(y_i) / $signed(bus_i);
            rem  = $signed(y_i) % $signed(bus_i);
        end
    end

    // Opcode decode; single-width operations leave the high word zero.
    always_comb begin
        lo = '0;
        hi = '0;
        case (opcode_i)
            OP_ADD, OP_ADD_ALT0, OP_ADD_ALT1, OP_ADD_ALT2, OP_ADD_ALT3: lo = y_i + bus_i;
            OP_SUB:              lo = y_i - bus_i;
            OP_AND, OP_AND_ALT:  lo = y_i & bus_i;
            OP_OR, OP_OR_ALT:    lo = y_i | bus_i;
            OP_SHR:              lo = y_i >> sh;
            OP_SHRA:             lo = $signed(y_i) >>> sh;
            OP_SHL:              lo = y_i << sh;
            OP_ROR:              lo = (y_i >> sh) | (y_i << sh_inv);
            OP_ROL:              lo = (y_i << sh) | (y_i >> sh_inv);
            OP_MUL:              {hi, lo} = prod;
            OP_DIV: begin
                lo = quot;
                hi = rem;
            end
            OP_NEG:              lo = -bus_i;
            OP_NOT:              lo = ~bus_i;
            default: begin
                lo = '0;
                hi = '0;
            end
        endcase
    end

    assign result_o = {hi, lo};

endmodule

// File: rtl/datapath.sv
// Phase-1 CPU datapath: register file and special registers on one shared bus.
module datapath
    import datapath_pkg::*;
#(
    parameter int unsigned WIDTH = datapath_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             R0in,  R1in,  R2in,  R3in,  R4in,  R5in,  R6in,  R7in,
    input  logic             R8in,  R9in,  R10in, R11in, R12in, R13in, R14in, R15in,
    input  logic             PCin,
    input  logic             HIin,
    input  logic             LOin,
    input  logic             MARin,
    input  logic             Yin,
    input  logic             Cin,
    input  logic             InPortin,
    input  logic             Zin,
    input  logic             MDRin,
    input  logic             Read,
    input  logic             incPC,
    input  logic [4:0]       opcode,
    input  logic [WIDTH-1:0] Mdatain,
    input  logic [WIDTH-1:0] InPort_data,
    input  logic             R0out, R1out, R2out,  R3out,  R4out,  R5out,  R6out,  R7out,
    input  logic             R8out, R9out, R10out, R11out, R12out, R13out, R14out, R15out,
    input  logic             HIout,
    input  logic             LOout,
    input  logic             ZHighOut,
    input  logic             ZLowOut,
    input  logic             PCout,
    input  logic             MDRout,
    input  logic             InPortOut,
    input  logic             Cout,
    output logic [WIDTH-1:0] bus_out,
    output logic [WIDTH-1:0] mar_out
);

    logic [15:0]              r_in;
    logic [15:0]              r_out;
    logic [15:0][WIDTH-1:0]   r_q, r_d;
    logic [WIDTH-1:0]         hi_q, hi_d, lo_q, lo_d, pc_q, pc_d, mar_q, mar_d;
    logic [WIDTH-1:0]         mdr_q, mdr_d, y_q, y_d, inport_q, inport_d, c_q, c_d;
    logic [2*WIDTH-1:0]       z_q, z_d;
    logic [2*WIDTH-1:0]       alu_res;
    logic [WIDTH-1:0]         bus;

    assign r_in  = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                    R7in,  R6in,  R5in,  R4in,  R3in,  R2in,  R1in, R0in};
    assign r_out = {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                    R7out,  R6out,  R5out,  R4out,  R3out,  R2out,  R1out, R0out};

    // Bus mux: lowest-priority source written first so higher-priority sources override.
    always_comb begin
        bus = '0;
        if (Cout)      bus = c_q;
        if (InPortOut) bus = inport_q;
        if (MDRout)    bus = mdr_q;
        if (PCout)     bus = pc_q;
        if (ZLowOut)   bus = z_q[WIDTH-1:0];
        if (ZHighOut)  bus = z_q[2*WIDTH-1:WIDTH];
        if (LOout)     bus = lo_q;
        if (HIout)     bus = hi_q;
        for (int i = 15; i >= 0; i--) begin
            if (r_out[i]) bus = r_q[i];
        end
    end

    assign bus_out = bus;
    assign mar_out = mar_q;

    datapath_alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .y_i      (y_q),
        .bus_i    (bus),
        .opcode_i (opcode),
        .result_o (alu_res)
    );

    // Next-state for every register: hold unless its load strobe is high.
    always_comb begin
        r_d = r_q;
        for (int i = 0; i < 16; i++) begin
            if (r_in[i]) r_d[i] = bus;
        end
        hi_d     = HIin     ? bus : hi_q;
        lo_d     = LOin     ? bus : lo_q;
        mar_d    = MARin    ? bus : mar_q;
        y_d      = Yin      ? bus : y_q;
        c_d      = Cin      ? bus : c_q;
        inport_d = InPortin ? InPort_data : inport_q;
        mdr_d    = MDRin    ? (Read ? Mdatain : bus) : mdr_q;
        z_d      = Zin      ? alu_res : z_q;
        pc_d     = pc_q;
        if (PCin)       pc_d = bus;
        else if (incPC) pc_d = pc_q + 1'b1;
    end

    // State registers with synchronous clear overriding all loads.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            pc_q     <= '0;
            mar_q    <= '0;
            mdr_q    <= '0;
            y_q      <= '0;
            z_q      <= '0;
            inport_q <= '0;
            c_q      <= '0;
        end else begin
            r_q      <= r_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            pc_q     <= pc_d;
            mar_q    <= mar_d;
            mdr_q    <= mdr_d;
            y_q      <= y_d;
            z_q      <= z_d;
            inport_q <= inport_d;
            c_q      <= c_d;
        end
    end

endmodule

// File: tb/tb_datapath.sv
// Directed self-checking bench for the phase-1 datapath.
module tb_datapath;

    logic        clk = 1'b0;
    logic        clr;
    logic [15:0] rin, rout;
    logic        PCin, HIin, LOin, MARin, Yin, Cin, InPortin, Zin, MDRin, Read, incPC;
    logic        HIout, LOout, ZHighOut, ZLowOut, PCout, MDRout, InPortOut, Cout;
    logic [4:0]  opcode;
    logic [31:0] Mdatain, InPort_data;
    logic [31:0] bus_out, mar_out;

    int n_err    = 0;
    int n_checks = 0;

    always #5 clk = ~clk;

    datapath dut (
        .clk(clk), .clr(clr),
        .R0in(rin[0]),   .R1in(rin[1]),   .R2in(rin[2]),   .R3in(rin[3]),
        .R4in(rin[4]),   .R5in(rin[5]),   .R6in(rin[6]),   .R7in(rin[7]),
        .R8in(rin[8]),   .R9in(rin[9]),   .R10in(rin[10]), .R11in(rin[11]),
        .R12in(rin[12]), .R13in(rin[13]), .R14in(rin[14]), .R15in(rin[15]),
        .PCin(PCin), .HIin(HIin), .LOin(LOin), .MARin(MARin), .Yin(Yin), .Cin(Cin),
        .InPortin(InPortin), .Zin(Zin), .MDRin(MDRin), .Read(Read), .incPC(incPC),
        .opcode(opcode), .Mdatain(Mdatain), .InPort_data(InPort_data),
        .R0out(rout[0]),   .R1out(rout[1]),   .R2out(rout[2]),   .R3out(rout[3]),
        .R4out(rout[4]),   .R5out(rout[5]),   .R6out(rout[6]),   .R7out(rout[7]),
        .R8out(rout[8]),   .R9out(rout[9]),   .R10out(rout[10]), .R11out(rout[11]),
        .R12out(rout[12]), .R13out(rout[13]), .R14out(rout[14]), .R15out(rout[15]),
        .HIout(HIout), .LOout(LOout), .ZHighOut(ZHighOut), .ZLowOut(ZLowOut),
        .PCout(PCout), .MDRout(MDRout), .InPortOut(InPortOut), .Cout(Cout),
        .bus_out(bus_out), .mar_out(mar_out)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $display("FAIL %s: observed=%h expected=%h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic clear_ctl();
        clr = 0; rin = '0; rout = '0;
        PCin = 0; HIin = 0; LOin = 0; MARin = 0; Yin = 0; Cin = 0; InPortin = 0;
        Zin = 0; MDRin = 0; Read = 0; incPC = 0; opcode = '0;
        HIout = 0; LOout = 0; ZHighOut = 0; ZLowOut = 0; PCout = 0; MDRout = 0;
        InPortOut = 0; Cout = 0; Mdatain = '0; InPort_data = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        clear_ctl();
    endtask

    // Sample the bus with whatever out strobes the caller set, then drop them.
    task automatic chk_bus(input string tag, input logic [31:0] exp);
        #1;
        check(tag, bus_out, exp);
        clear_ctl();
    endtask

    task automatic mdr_load(input logic [31:0] v);
        Mdatain = v; Read = 1; MDRin = 1;
        tick();
    endtask

    task automatic load_reg(input int n, input logic [31:0] v);
        mdr_load(v);
        MDRout = 1; rin[n] = 1;
        tick();
    endtask

    task automatic alu_run(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op);
        mdr_load(a);
        MDRout = 1; Yin = 1;
        tick();
        mdr_load(b);
        MDRout = 1; opcode = op; Zin = 1;
        tick();
    endtask

    task automatic chk_z(input string tag, input logic [31:0] hi, input logic [31:0] lo);
        ZLowOut = 1;
        chk_bus({tag, "_lo"}, lo);
        ZHighOut = 1;
        chk_bus({tag, "_hi"}, hi);
    endtask

    initial begin
        clear_ctl();
        clr = 1;
        tick();

        // Reset state
        chk_bus("idle_bus", 32'h0);
        check("rst_mar", mar_out, 32'h0);
        PCout = 1;  chk_bus("rst_pc", 32'h0);
        rout[0] = 1; chk_bus("rst_r0", 32'h0);
        chk_z("rst_z", 32'h0, 32'h0);

        // PC increment and load priority
        repeat (3) begin incPC = 1; tick(); end
        PCout = 1; chk_bus("pc_inc3", 32'h3);
        mdr_load(32'h100);
        MDRout = 1; PCin = 1; incPC = 1; tick();
        PCout = 1; chk_bus("pc_load_pri", 32'h100);
        load_reg(0, 32'hFFFF_FFFF);
        rout[0] = 1; PCin = 1; tick();
        incPC = 1; tick();
        PCout = 1; chk_bus("pc_wrap", 32'h0);

        // AND through registers
        load_reg(2, 32'h0000_000A);
        load_reg(3, 32'h0000_0014);
        load_reg(1, 32'h0000_0018);
        rout[1] = 1; chk_bus("r1_pre", 32'h18);
        rout[2] = 1; Yin = 1; tick();
        rout[3] = 1; opcode = 5'b00101; Zin = 1; tick();
        ZLowOut = 1; rin[1] = 1;
        #1 check("and_bus", bus_out, 32'h0);
        tick();
        rout[1] = 1; chk_bus("and_r1", 32'h0);

        // Arithmetic
        alu_run(32'hFFFF_FFFF, 32'h1, 5'b00011); chk_z("add_wrap", 32'h0, 32'h0);
        alu_run(32'h5, 32'h7, 5'b00100);         chk_z("sub", 32'h0, 32'hFFFF_FFFE);
        alu_run(32'h10, 32'hFFFF_FFFE, 5'b01111); chk_z("mul", 32'hFFFF_FFFF, 32'hFFFF_FFE0);
        alu_run(32'h10, 32'hFFFF_FFFE, 5'b10000); chk_z("div", 32'h0, 32'hFFFF_FFF8);
        alu_run(32'h7, 32'h0, 5'b10000);          chk_z("div0", 32'h7, 32'hFFFF_FFFF);
        alu_run(32'hFFFF_FFF9, 32'h2, 5'b10000);  chk_z("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        alu_run(32'h0, 32'h1, 5'b10001);          chk_z("neg", 32'h0, 32'hFFFF_FFFF);
        alu_run(32'h0, 32'h1, 5'b10010);          chk_z("not", 32'h0, 32'hFFFF_FFFE);
        alu_run(32'hC, 32'hA, 5'b01101);          chk_z("and_alt", 32'h0, 32'h8);
        alu_run(32'hC, 32'hA, 5'b00110);          chk_z("or", 32'h0, 32'hE);
        alu_run(32'h3, 32'h4, 5'b01100);          chk_z("add_alt", 32'h0, 32'h7);
        alu_run(32'h3, 32'h4, 5'b10011);          chk_z("unlisted", 32'h0, 32'h0);

        // Shifts and rotates
        alu_run(32'h8000_0001, 32'h1, 5'b01000); chk_z("shra", 32'h0, 32'hC000_0000);
        alu_run(32'h8000_0001, 32'h1, 5'b00111); chk_z("shr", 32'h0, 32'h4000_0000);
        alu_run(32'h8000_0001, 32'h1, 5'b01010); chk_z("ror", 32'h0, 32'hC000_0000);
        alu_run(32'h8000_0001, 32'h1, 5'b01011); chk_z("rol", 32'h0, 32'h0000_0003);
        alu_run(32'h8000_0001, 32'h1, 5'b01001); chk_z("shl", 32'h0, 32'h0000_0002);
        alu_run(32'h8000_0001, 32'h24, 5'b01011); chk_z("rol_amt5", 32'h0, 32'h0000_0018);

        // Bus priority and special registers
        load_reg(5, 32'h55);
        load_reg(7, 32'h77);
        rout[5] = 1; rout[7] = 1; chk_bus("pri_r5_r7", 32'h55);
        mdr_load(32'h1111); MDRout = 1; HIin = 1; tick();
        mdr_load(32'h2222); MDRout = 1; LOin = 1; tick();
        HIout = 1; LOout = 1; MDRout = 1; chk_bus("pri_hi_lo", 32'h1111);
        rout[15] = 1; HIout = 1; chk_bus("pri_r15_hi", 32'h0);
        rout[7] = 1; MARin = 1; tick();
        check("mar", mar_out, 32'h77);
        InPort_data = 32'hDEAD; InPortin = 1; tick();
        InPortOut = 1; Cout = 1; chk_bus("inport", 32'hDEAD);
        rout[5] = 1; Cin = 1; rin[5] = 1; tick();
        Cout = 1; chk_bus("c_same_edge", 32'h55);
        rout[5] = 1; chk_bus("r5_same_edge", 32'h55);
        mdr_load(32'h9);
        MDRout = 1; MDRin = 1; tick();
        MDRout = 1; chk_bus("mdr_from_bus", 32'h9);

        // Clear overrides loads
        clr = 1; MDRin = 1; Read = 1; Mdatain = 32'h1234; rin[1] = 1; tick();
        MDRout = 1;    chk_bus("clr_mdr", 32'h0);
        rout[1] = 1;   chk_bus("clr_r1", 32'h0);
        rout[5] = 1;   chk_bus("clr_r5", 32'h0);
        HIout = 1;     chk_bus("clr_hi", 32'h0);
        LOout = 1;     chk_bus("clr_lo", 32'h0);
        PCout = 1;     chk_bus("clr_pc", 32'h0);
        Cout = 1;      chk_bus("clr_c", 32'h0);
        InPortOut = 1; chk_bus("clr_inport", 32'h0);
        check("clr_mar", mar_out, 32'h0);
        chk_z("clr_z", 32'h0, 32'h0);
        // Y cleared: Y + 3 must give 3
        load_reg(1, 32'h3);
        rout[1] = 1; opcode = 5'b00011; Zin = 1; tick();
        chk_z("clr_y", 32'h0, 32'h3);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
